// File: rtl/xc_malu_pkg.sv
// Shared constants and types for the MALU sequencer and its step datapath.
package xc_malu_pkg;

  localparam logic [1:0] MALU_IDLE = 2'd0;
  localparam logic [1:0] MALU_RUN  = 2'd1;
  localparam logic [1:0] MALU_DONE = 2'd2;

  // Bit positions within the one-hot op select.
  localparam int OP_DIV    = 0;
  localparam int OP_DIVU   = 1;
  localparam int OP_REM    = 2;
  localparam int OP_REMU   = 3;
  localparam int OP_MUL    = 4;
  localparam int OP_MULU   = 5;
  localparam int OP_MULSU  = 6;
  localparam int OP_CLMUL  = 7;
  localparam int OP_PMUL   = 8;
  localparam int OP_PCLMUL = 9;

  localparam int MALU_OPW       = 10;
  localparam int MALU_CW        = 6;
  localparam int MALU_MAX_STEPS = 34;

  typedef struct packed {
    logic [63:0] acc;
    logic [31:0] arg_0;
    logic [31:0] arg_1;
  } malu_iter_t;

endpackage

// File: rtl/xc_malu_seq_if.sv
// Core handshake plus step-datapath bundle between the MALU sequencer and its neighbours.
interface xc_malu_seq_if
  import xc_malu_pkg::*;
#(
  parameter int CW  = MALU_CW,
  parameter int OPW = MALU_OPW
);

  logic           valid;
  logic           flush;
  logic [OPW-1:0] op;
  logic [63:0]    init_acc;
  logic [31:0]    init_arg_0;
  logic [31:0]    init_arg_1;
  logic [63:0]    dp_n_acc;
  logic [31:0]    dp_n_arg_0;
  logic [31:0]    dp_n_arg_1;
  logic           dp_ready;
  logic [63:0]    dp_result;

  logic [OPW-1:0] op_q;
  logic [CW-1:0]  count;
  logic [63:0]    acc;
  logic [31:0]    arg_0;
  logic [31:0]    arg_1;
  logic           busy;
  logic           ready;
  logic [63:0]    result;
  logic           timeout;

  // The master side covers both the core request and the step datapath.
  modport master (
    output valid, flush, op, init_acc, init_arg_0, init_arg_1,
    output dp_n_acc, dp_n_arg_0, dp_n_arg_1, dp_ready, dp_result,
    input  op_q, count, acc, arg_0, arg_1, busy, ready, result, timeout
  );

  modport slave (
    input  valid, flush, op, init_acc, init_arg_0, init_arg_1,
    input  dp_n_acc, dp_n_arg_0, dp_n_arg_1, dp_ready, dp_result,
    output op_q, count, acc, arg_0, arg_1, busy, ready, result, timeout
  );

endinterface

// File: rtl/xc_malu_seq.sv
// MALU multi-cycle sequencer: owns the iteration registers, the op latch and the
// start/complete handshake with flush, abort and a step watchdog.
module xc_malu_seq
  import xc_malu_pkg::*;
#(
  parameter int CW        = MALU_CW,
  parameter int MAX_STEPS = MALU_MAX_STEPS,
  parameter int OPW       = MALU_OPW
) (
  input logic          clock,
  input logic          reset,
  xc_malu_seq_if.slave bus
);

  localparam logic [CW-1:0] LAST_STEP = CW'(MAX_STEPS - 1);

  logic [1:0]     state_q,   state_d;
  logic [CW-1:0]  count_q,   count_d;
  malu_iter_t     iter_q,    iter_d;
  logic [OPW-1:0] op_sel_q,  op_sel_d;
  logic [63:0]    result_q,  result_d;
  logic           timeout_q, timeout_d;
  logic           busy_q,    busy_d;
  logic           ready_q,   ready_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    count_d   = count_q;
    iter_d    = iter_q;
    op_sel_d  = op_sel_q;
    result_d  = result_q;
    timeout_d = timeout_q;

    case (state_q)
      MALU_IDLE: begin
        if (bus.valid && !bus.flush) begin
          iter_d   = '{acc: bus.init_acc, arg_0: bus.init_arg_0, arg_1: bus.init_arg_1};
          op_sel_d = bus.op;
          count_d  = '0;
          state_d  = MALU_RUN;
        end
      end
      MALU_RUN: begin
        // Abort beats completion: a withdrawn request must never produce ready.
        if (bus.flush || !bus.valid) begin
          count_d = '0;
          state_d = MALU_IDLE;
        end else if (bus.dp_ready) begin
          result_d  = bus.dp_result;
          timeout_d = 1'b0;
          state_d   = MALU_DONE;
        end else if (count_q == LAST_STEP) begin
          result_d  = bus.dp_result;
          timeout_d = 1'b1;
          state_d   = MALU_DONE;
        end else begin
          iter_d  = '{acc: bus.dp_n_acc, arg_0: bus.dp_n_arg_0, arg_1: bus.dp_n_arg_1};
          count_d = count_q + CW'(1);
        end
      end
      MALU_DONE: begin
        count_d = '0;
        state_d = MALU_IDLE;
      end
      default: begin
        count_d = '0;
        state_d = MALU_IDLE;
      end
    endcase

    // Status flags are decoded from the next state so they leave the block registered.
    busy_d  = (state_d == MALU_RUN);
    ready_d = (state_d == MALU_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= MALU_IDLE;
      count_q   <= '0;
      iter_q    <= '0;
      op_sel_q  <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q   <= state_d;
      count_q   <= count_d;
      iter_q    <= iter_d;
      op_sel_q  <= op_sel_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.op_q    = op_sel_q;
  assign bus.count   = count_q;
  assign bus.acc     = iter_q.acc;
  assign bus.arg_0   = iter_q.arg_0;
  assign bus.arg_1   = iter_q.arg_1;
  assign bus.busy    = busy_q;
  assign bus.ready   = ready_q;
  assign bus.result  = result_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_xc_malu_seq.sv
// Self-checking bench for xc_malu_seq: transaction-level model with per-cycle compare,
// a datapath stub driven from the model, and directed scenarios with literal expectations.
module tb_xc_malu_seq;
  import xc_malu_pkg::*;

  localparam int CW        = 6;
  localparam int MAX_STEPS = 34;
  localparam int OPW       = 10;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  xc_malu_seq_if #(.CW(CW), .OPW(OPW)) bus ();

  xc_malu_seq #(.CW(CW), .MAX_STEPS(MAX_STEPS), .OPW(OPW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an operation is either absent, running (with its step index), or just finished.
  bit             m_run     = 1'b0;
  bit             m_done    = 1'b0;
  int             m_count   = 0;
  logic [63:0]    m_acc     = '0;
  logic [31:0]    m_arg0    = '0;
  logic [31:0]    m_arg1    = '0;
  logic [OPW-1:0] m_op      = '0;
  logic [63:0]    m_result  = '0;
  bit             m_timeout = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_run <= 1'b0; m_done <= 1'b0; m_count <= 0;
      m_acc <= '0; m_arg0 <= '0; m_arg1 <= '0; m_op <= '0;
      m_result <= '0; m_timeout <= 1'b0;
    end else if (m_done) begin
      m_done  <= 1'b0;
      m_count <= 0;
    end else if (!m_run) begin
      if (bus.valid && !bus.flush) begin
        m_run <= 1'b1; m_count <= 0; m_op <= bus.op;
        m_acc <= bus.init_acc; m_arg0 <= bus.init_arg_0; m_arg1 <= bus.init_arg_1;
      end
    end else if (bus.flush || !bus.valid) begin
      m_run   <= 1'b0;
      m_count <= 0;
    end else if (bus.dp_ready || m_count == MAX_STEPS - 1) begin
      m_run     <= 1'b0;
      m_done    <= 1'b1;
      m_result  <= bus.dp_result;
      m_timeout <= !bus.dp_ready;
    end else begin
      m_acc   <= bus.dp_n_acc;
      m_arg0  <= bus.dp_n_arg_0;
      m_arg1  <= bus.dp_n_arg_1;
      m_count <= m_count + 1;
    end
  end

  // Datapath stub, driven from the model so DUT errors cannot leak into expectations.
  int          ready_at = -1;
  logic [63:0] res_val  = '0;

  initial begin
    bus.dp_n_acc = '0; bus.dp_n_arg_0 = '0; bus.dp_n_arg_1 = '0;
    bus.dp_ready = 1'b0; bus.dp_result = '0;
    forever begin
      @(negedge clock);
      #1;
      bus.dp_n_acc   = m_acc + 64'd1;
      bus.dp_n_arg_0 = m_arg0 + 32'h10;
      bus.dp_n_arg_1 = m_arg1 - 32'd1;
      bus.dp_ready   = (ready_at >= 0) && (m_count == ready_at);
      bus.dp_result  = res_val;
    end
  end

  initial forever begin
    @(negedge clock);
    if (!reset) begin
      check("cyc_busy",    64'(bus.busy),    64'(m_run));
      check("cyc_ready",   64'(bus.ready),   64'(m_done));
      check("cyc_count",   64'(bus.count),   64'(m_count));
      check("cyc_acc",     bus.acc,          m_acc);
      check("cyc_arg_0",   64'(bus.arg_0),   64'(m_arg0));
      check("cyc_arg_1",   64'(bus.arg_1),   64'(m_arg1));
      check("cyc_op_q",    64'(bus.op_q),    64'(m_op));
      check("cyc_result",  bus.result,       m_result);
      check("cyc_timeout", 64'(bus.timeout), 64'(m_timeout));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "time limit");
  end

  // Caller is at negedge+1. Returns at negedge+1 after ready or after an abort settles.
  task automatic run_op(input logic [OPW-1:0] op_v, input logic [63:0] acc0, input int rdy,
                        input int abort_at, input bit abort_flush, input bit keep_valid,
                        input bit do_step, output int lat, output int busy_n,
                        output int max_cnt, output bit saw);
    bit aborted = 1'b0;
    int post = 0;
    lat = 0; busy_n = 0; max_cnt = 0; saw = 1'b0;
    ready_at       = rdy;
    bus.op         = op_v;
    bus.init_acc   = acc0;
    bus.init_arg_0 = acc0[31:0] ^ 32'hA5A5_0000;
    bus.init_arg_1 = 32'h100;
    bus.valid      = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      if (bus.busy) begin
        busy_n++;
        if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
        if (do_step && c <= 4) begin
          check("step_acc",   bus.acc,          acc0 + 64'(c - 1));
          check("step_count", 64'(bus.count),   64'(c - 1));
        end
      end
      if (bus.ready) begin
        saw = 1'b1;
        lat = c;
        break;
      end
      if (aborted) begin
        post++;
        if (post == 1) begin
          check("abort_busy",  64'(bus.busy),  64'd0);
          check("abort_count", 64'(bus.count), 64'd0);
        end
        if (post == 4) break;
      end else if (abort_at >= 0 && bus.busy && int'(bus.count) == abort_at) begin
        #1;
        if (abort_flush) bus.flush = 1'b1;
        else             bus.valid = 1'b0;
        aborted = 1'b1;
      end
    end
    #1;
    if (!keep_valid) bus.valid = 1'b0;
    bus.flush = 1'b0;
  endtask

  initial begin
    int lat, busy_n, max_cnt;
    bit saw;
    bus.valid = 1'b0; bus.flush = 1'b0; bus.op = '0;
    bus.init_acc = '0; bus.init_arg_0 = '0; bus.init_arg_1 = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    check("rst_busy",    64'(bus.busy),    64'd0);
    check("rst_ready",   64'(bus.ready),   64'd0);
    check("rst_count",   64'(bus.count),   64'd0);
    check("rst_acc",     bus.acc,          64'd0);
    check("rst_result",  bus.result,       64'd0);
    check("rst_op_q",    64'(bus.op_q),    64'd0);
    check("rst_timeout", 64'(bus.timeout), 64'd0);
    #1;

    // Per-step update: acc 5,6,7,8 over counts 0..3, result on the fourth RUN cycle.
    res_val = 64'hC0FF_EE00_0000_0003;
    run_op(OPW'(1) << OP_MUL, 64'h5, 3, -1, 1'b0, 1'b0, 1'b1, lat, busy_n, max_cnt, saw);
    check("step_ready",   64'(saw),         64'd1);
    check("step_latency", 64'(lat),         64'd5);
    check("step_busy",    64'(busy_n),      64'd4);
    check("step_result",  bus.result,       64'hC0FF_EE00_0000_0003);
    check("step_timeout", 64'(bus.timeout), 64'd0);
    repeat (2) @(negedge clock);
    #1;

    // Basic completion at count 31: 32 busy cycles, ready 33 edges after the start sample.
    res_val = 64'h1234_5678_9ABC_DEF0;
    run_op(OPW'(1) << OP_DIV, 64'h5, 31, -1, 1'b0, 1'b0, 1'b0, lat, busy_n, max_cnt, saw);
    check("basic_ready",   64'(saw),         64'd1);
    check("basic_latency", 64'(lat),         64'd33);
    check("basic_busy",    64'(busy_n),      64'd32);
    check("basic_result",  bus.result,       64'h1234_5678_9ABC_DEF0);
    check("basic_timeout", 64'(bus.timeout), 64'd0);
    repeat (2) @(negedge clock);
    #1;

    // Flush at count 10: no ready, result keeps the previous completion.
    res_val = 64'hBAD0_BAD0_BAD0_BAD0;
    run_op(OPW'(1) << OP_DIVU, 64'h40, 20, 10, 1'b1, 1'b0, 1'b0, lat, busy_n, max_cnt, saw);
    check("flush_no_ready", 64'(saw),   64'd0);
    check("flush_result",   bus.result, 64'h1234_5678_9ABC_DEF0);
    repeat (2) @(negedge clock);
    #1;

    // Valid withdrawn at count 5: same abort behaviour as flush.
    run_op(OPW'(1) << OP_REMU, 64'h80, 20, 5, 1'b0, 1'b0, 1'b0, lat, busy_n, max_cnt, saw);
    check("drop_no_ready", 64'(saw),   64'd0);
    check("drop_result",   bus.result, 64'h1234_5678_9ABC_DEF0);
    repeat (2) @(negedge clock);
    #1;

    // Watchdog with a zero op and dp_ready never raised: 34 RUN cycles, counts 0..33.
    res_val = 64'h0000_0000_DEAD_BEEF;
    run_op('0, 64'h7, -1, -1, 1'b0, 1'b0, 1'b0, lat, busy_n, max_cnt, saw);
    check("wdog_ready",   64'(saw),         64'd1);
    check("wdog_latency", 64'(lat),         64'd35);
    check("wdog_busy",    64'(busy_n),      64'd34);
    check("wdog_max_cnt", 64'(max_cnt),     64'd33);
    check("wdog_timeout", 64'(bus.timeout), 64'd1);
    check("wdog_result",  bus.result,       64'h0000_0000_DEAD_BEEF);
    repeat (2) @(negedge clock);
    #1;

    // Back-to-back with valid held: second op starts from the IDLE cycle after DONE.
    res_val = 64'h0000_0000_0000_0A0A;
    run_op(OPW'(1) << OP_REM, 64'h11, 2, -1, 1'b0, 1'b1, 1'b0, lat, busy_n, max_cnt, saw);
    check("b2b1_ready",   64'(saw),       64'd1);
    check("b2b1_latency", 64'(lat),       64'd4);
    check("b2b1_result",  bus.result,     64'h0000_0000_0000_0A0A);
    res_val = 64'h0000_0000_0000_0B0B;
    run_op(OPW'(1) << OP_PCLMUL, 64'h22, 1, -1, 1'b0, 1'b1, 1'b0, lat, busy_n, max_cnt, saw);
    check("b2b2_ready",   64'(saw),         64'd1);
    check("b2b2_latency", 64'(lat),         64'd4);
    check("b2b2_op_q",    64'(bus.op_q),    64'h200);
    check("b2b2_result",  bus.result,       64'h0000_0000_0000_0B0B);
    check("b2b2_timeout", 64'(bus.timeout), 64'd0);
    bus.valid = 1'b0;
    repeat (2) @(negedge clock);
    #1;

    // Asynchronous reset in the middle of RUN clears every output before the next edge.
    ready_at = -1;
    bus.op = OPW'(1) << OP_MULSU; bus.init_acc = 64'h99; bus.valid = 1'b1;
    repeat (6) @(negedge clock);
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("arst_busy",    64'(bus.busy),    64'd0);
    check("arst_ready",   64'(bus.ready),   64'd0);
    check("arst_count",   64'(bus.count),   64'd0);
    check("arst_acc",     bus.acc,          64'd0);
    check("arst_arg_0",   64'(bus.arg_0),   64'd0);
    check("arst_arg_1",   64'(bus.arg_1),   64'd0);
    check("arst_op_q",    64'(bus.op_q),    64'd0);
    check("arst_result",  bus.result,       64'd0);
    check("arst_timeout", 64'(bus.timeout), 64'd0);
    bus.valid = 1'b0;
    @(negedge clock);
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
